// File: rtl/dut_vector_sequencer_pkg.sv
// Shared types, LFSR/MISR tap constants and step functions for the vector sequencer.
package vseq_pkg;

    localparam int SIG_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        APPLY   = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } vseq_state_t;

    // Tap positions 14,5,3,1 and 16,15,13,4 expressed as bit masks (bit n-1 for tap n).
    localparam logic [13:0]      LFSR14_TAPS = 14'h2015;
    localparam logic [SIG_W-1:0] MISR16_TAPS = 16'hD008;

    function automatic logic [13:0] step14(input logic [13:0] l);
        return {l[12:0], ^(l & LFSR14_TAPS)};
    endfunction

    function automatic logic [SIG_W-1:0] step16(input logic [SIG_W-1:0] m);
        return {m[SIG_W-2:0], ^(m & MISR16_TAPS)};
    endfunction

endpackage

// File: rtl/dut_vector_sequencer_if.sv
// Host-side run control and signature handshake bundle for the vector sequencer.
interface vseq_if #(
    parameter int IN_W  = 14,
    parameter int CNT_W = 16
);
    import vseq_pkg::*;

    logic             start;
    logic             abort;
    logic [IN_W-1:0]  seed;
    logic [CNT_W-1:0] num_vec;
    logic             busy;
    logic             sig_valid;
    logic             sig_ready;
    logic [SIG_W-1:0] signature;

    modport master (
        output start, abort, seed, num_vec, sig_ready,
        input  busy, sig_valid, signature
    );

    modport slave (
        input  start, abort, seed, num_vec, sig_ready,
        output busy, sig_valid, signature
    );

endinterface

// File: rtl/dut_vector_sequencer_misr.sv
// 16-bit multiple-input signature register compacting netlist responses.
// With VSEQ_XMASK_EN defined, an x_mask input excludes selected response bits.
module vseq_misr
    import vseq_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
`ifdef VSEQ_XMASK_EN
    input  logic [OUT_W-1:0] x_mask,
`endif
    input  logic [OUT_W-1:0] data,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] misr_q;
    logic [SIG_W-1:0] misr_d;
    logic [OUT_W-1:0] data_eff;

`ifdef VSEQ_XMASK_EN
    assign data_eff = data & ~x_mask;
`else
    assign data_eff = data;
`endif

    always_comb begin
        misr_d = misr_q;
        if (clear) begin
            misr_d = '0;
        end else if (enable) begin
            misr_d = step16(misr_q) ^ SIG_W'(data_eff);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misr_q <= '0;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign sig = misr_q;

endmodule

// File: rtl/dut_vector_sequencer.sv
// Drives LFSR vectors into a mapped netlist, holds each for SETTLE cycles, and
// compacts responses into a MISR signature. Optional macro: VSEQ_XMASK_EN.
module dut_vector_sequencer
#(
    parameter int IN_W   = 14,
    parameter int OUT_W  = 8,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    vseq_if.slave            host,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out
`ifdef VSEQ_XMASK_EN
    ,
    input  logic [OUT_W-1:0] x_mask
`endif
);
    import vseq_pkg::*;

    localparam logic [2:0] ST_IDLE    = vseq_pkg::IDLE;
    localparam logic [2:0] ST_LOAD    = vseq_pkg::LOAD;
    localparam logic [2:0] ST_APPLY   = vseq_pkg::APPLY;
    localparam logic [2:0] ST_SETTLE  = vseq_pkg::SETTLE;
    localparam logic [2:0] ST_CAPTURE = vseq_pkg::CAPTURE;
    localparam logic [2:0] ST_DONE    = vseq_pkg::DONE;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    logic [2:0]       state_q, state_d;
    logic [IN_W-1:0]  lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       settle_cnt_q, settle_cnt_d;
    logic [IN_W-1:0]  dut_in_q, dut_in_d;
    logic             misr_clear;
    logic             misr_en;
    logic [SIG_W-1:0] misr_sig;

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        cnt_d        = cnt_q;
        settle_cnt_d = settle_cnt_q;
        dut_in_d     = dut_in_q;
        misr_clear   = 1'b0;
        misr_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (host.start) begin
                    // An all-zero seed would lock the LFSR, so it is replaced by 1.
                    lfsr_d     = (host.seed == '0) ? IN_W'(1) : host.seed;
                    cnt_d      = host.num_vec;
                    misr_clear = 1'b1;
                    state_d    = (host.num_vec == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_APPLY;
            end
            ST_APPLY: begin
                dut_in_d     = lfsr_q;
                settle_cnt_d = SETTLE_LOAD;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                misr_en = 1'b1;
                lfsr_d  = step14(lfsr_q);
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q <= CNT_W'(1)) ? ST_DONE : ST_APPLY;
            end
            ST_DONE: begin
                if (host.sig_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything; the MISR and applied vector are left frozen.
        if (host.abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            lfsr_d       = lfsr_q;
            cnt_d        = cnt_q;
            settle_cnt_d = settle_cnt_q;
            dut_in_d     = dut_in_q;
            misr_clear   = 1'b0;
            misr_en      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= '0;
            cnt_q        <= '0;
            settle_cnt_q <= '0;
            dut_in_q     <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cnt_q        <= cnt_d;
            settle_cnt_q <= settle_cnt_d;
            dut_in_q     <= dut_in_d;
        end
    end

    vseq_misr #(
        .OUT_W (OUT_W)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (misr_clear),
        .enable (misr_en),
`ifdef VSEQ_XMASK_EN
        .x_mask (x_mask),
`endif
        .data   (dut_out),
        .sig    (misr_sig)
    );

    assign dut_in         = dut_in_q;
    assign host.busy      = (state_q != ST_IDLE);
    assign host.sig_valid = (state_q == ST_DONE);
    assign host.signature = misr_sig;

endmodule

// File: tb/tb_dut_vector_sequencer.sv
// Directed-vector bench for dut_vector_sequencer with hand-computed expectations.
module tb_dut_vector_sequencer;

    logic        clk;
    logic        rst_n;
    logic [13:0] dut_in;
    logic [7:0]  dut_out;
`ifdef VSEQ_XMASK_EN
    logic [7:0]  x_mask;
`endif

    int n_vectors;
    int n_miscompares;

    vseq_if #(.IN_W(14), .CNT_W(16)) host_if ();

    dut_vector_sequencer #(
        .IN_W   (14),
        .OUT_W  (8),
        .CNT_W  (16),
        .SETTLE (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .host    (host_if),
        .dut_in  (dut_in),
        .dut_out (dut_out)
`ifdef VSEQ_XMASK_EN
        ,
        .x_mask  (x_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic start, input logic abort, input logic [13:0] seed,
                                 input logic [15:0] num_vec, input logic sig_ready);
        host_if.start     = start;
        host_if.abort     = abort;
        host_if.seed      = seed;
        host_if.num_vec   = num_vec;
        host_if.sig_ready = sig_ready;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vectors++;
        assert (observed === expected) else begin
            n_miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        rst_n         = 1'b0;
        dut_out       = 8'hA5;
`ifdef VSEQ_XMASK_EN
        x_mask        = 8'h00;
`endif
        applyStimulus(1'b0, 1'b0, 14'h0000, 16'd0, 1'b0);
        #1;
        checkOutput("reset_busy", 32'(host_if.busy), 32'd0);
        checkOutput("reset_sig_valid", 32'(host_if.sig_valid), 32'd0);
        checkOutput("reset_dut_in", 32'(dut_in), 32'd0);
        checkOutput("reset_signature", 32'(host_if.signature), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Single vector, seed 1, response A5
        $display("[TB] single vector");
        applyStimulus(1'b1, 1'b0, 14'h0001, 16'd1, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 14'h0000, 16'd0, 1'b0);
        checkOutput("single_busy", 32'(host_if.busy), 32'd1);
        tick(2);
        checkOutput("single_dut_in", 32'(dut_in), 32'h0001);
        tick(2);
        checkOutput("single_no_valid_early", 32'(host_if.sig_valid), 32'd0);
        tick(1);
        checkOutput("single_valid_at_5", 32'(host_if.sig_valid), 32'd1);
        checkOutput("single_signature", 32'(host_if.signature), 32'h00A5);

        // Host stalls for 10 cycles; a start in this window must be ignored
        for (int i = 0; i < 10; i++) begin
            if (i == 3) applyStimulus(1'b1, 1'b0, 14'h0005, 16'd3, 1'b0);
            else        applyStimulus(1'b0, 1'b0, 14'h0000, 16'd0, 1'b0);
            tick(1);
            checkOutput("stall_valid", 32'(host_if.sig_valid), 32'd1);
            checkOutput("stall_signature", 32'(host_if.signature), 32'h00A5);
        end
        checkOutput("stall_dut_in", 32'(dut_in), 32'h0001);
        applyStimulus(1'b0, 1'b0, 14'h0000, 16'd0, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b0, 14'h0000, 16'd0, 1'b0);
        checkOutput("handshake_valid_drop", 32'(host_if.sig_valid), 32'd0);
        checkOutput("handshake_busy_drop", 32'(host_if.busy), 32'd0);
        checkOutput("idle_dut_in_hold", 32'(dut_in), 32'h0001);

        // Two vectors: 0001 then 0003, signature 01EF
        $display("[TB] two vectors");
        applyStimulus(1'b1, 1'b0, 14'h0001, 16'd2, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 14'h0000, 16'd0, 1'b0);
        tick(2);
        checkOutput("two_vec1", 32'(dut_in), 32'h0001);
        tick(4);
        checkOutput("two_vec2", 32'(dut_in), 32'h0003);
        tick(3);
        checkOutput("two_valid", 32'(host_if.sig_valid), 32'd1);
        checkOutput("two_signature", 32'(host_if.signature), 32'h01EF);
        applyStimulus(1'b0, 1'b0, 14'h0000, 16'd0, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b0, 14'h0000, 16'd0, 1'b0);
        checkOutput("two_idle", 32'(host_if.busy), 32'd0);

        // Zero count goes straight to DONE with a cleared signature
        $display("[TB] zero count");
        applyStimulus(1'b1, 1'b0, 14'h0001, 16'd0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 14'h0000, 16'd0, 1'b0);
        checkOutput("zero_valid", 32'(host_if.sig_valid), 32'd1);
        checkOutput("zero_signature", 32'(host_if.signature), 32'h0000);
        checkOutput("zero_dut_in_hold", 32'(dut_in), 32'h0003);
        applyStimulus(1'b0, 1'b0, 14'h0000, 16'd0, 1'b1);
        tick(1);

        // Zero seed substitutes vector 0001
        $display("[TB] zero seed");
        applyStimulus(1'b1, 1'b0, 14'h0000, 16'd1, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 14'h0000, 16'd0, 1'b0);
        tick(2);
        checkOutput("zero_seed_vec", 32'(dut_in), 32'h0001);
        tick(3);
        checkOutput("zero_seed_signature", 32'(host_if.signature), 32'h00A5);
        applyStimulus(1'b0, 1'b0, 14'h0000, 16'd0, 1'b1);
        tick(1);

        // Abort during the third vector (0007) freezes dut_in and the MISR
        $display("[TB] abort");
        applyStimulus(1'b1, 1'b0, 14'h0001, 16'd5, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 14'h0000, 16'd0, 1'b0);
        tick(10);
        checkOutput("abort_vec3", 32'(dut_in), 32'h0007);
        applyStimulus(1'b0, 1'b1, 14'h0000, 16'd0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 14'h0000, 16'd0, 1'b0);
        checkOutput("abort_busy", 32'(host_if.busy), 32'd0);
        checkOutput("abort_dut_in_hold", 32'(dut_in), 32'h0007);
        checkOutput("abort_misr_hold", 32'(host_if.signature), 32'h01EF);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput("abort_no_valid", 32'(host_if.sig_valid), 32'd0);
        end

        // Start and abort together in IDLE: start wins
        $display("[TB] start with abort in idle");
        applyStimulus(1'b1, 1'b1, 14'h0001, 16'd1, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 14'h0000, 16'd0, 1'b0);
        checkOutput("start_abort_busy", 32'(host_if.busy), 32'd1);

        // Asynchronous reset in the middle of SETTLE
        $display("[TB] async reset");
        tick(2);
        checkOutput("pre_reset_dut_in", 32'(dut_in), 32'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_busy", 32'(host_if.busy), 32'd0);
        checkOutput("async_sig_valid", 32'(host_if.sig_valid), 32'd0);
        checkOutput("async_dut_in", 32'(dut_in), 32'd0);
        checkOutput("async_signature", 32'(host_if.signature), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);

`ifdef VSEQ_XMASK_EN
        $display("[TB] x mask");
        x_mask = 8'hF0;
        applyStimulus(1'b1, 1'b0, 14'h0001, 16'd1, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 14'h0000, 16'd0, 1'b0);
        tick(5);
        checkOutput("xmask_valid", 32'(host_if.sig_valid), 32'd1);
        checkOutput("xmask_signature", 32'(host_if.signature), 32'h0005);
        applyStimulus(1'b0, 1'b0, 14'h0000, 16'd0, 1'b1);
        tick(1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
